sram_word_ctrl: RTL

Memory-side controller between the dual-core SRAM arbiter and the external 16-bit asynchronous SRAM. It accepts one 32-bit word read or write per request from the arbiter's muxed port (`we`, `re`, `addr`, `wd`). It performs the transfer as two sequential half-word SRAM accesses and returns `rd_data`. It also provides the `stall` signal the arbiter and cores use to hold their memory stage.

---
 rtl/sram_word_ctrl_if.sv | 26 ++
 rtl/sram_word_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sram_word_ctrl_if.sv
// Word-request bus between the dual-core SRAM arbiter and the SRAM word
// controller: one 32-bit read or write per request, held by the requester
// while stall is high.
interface sram_word_ctrl_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wd;
  logic              stall;
  logic [DATA_W-1:0] rd_data;

  // Requester side (arbiter / testbench)
  modport master (
    output we, re, addr, wd,
    input  stall, rd_data
  );

  // Controller side
  modport slave (
    input  we, re, addr, wd,
    output stall, rd_data
  );
endinterface

// File: rtl/sram_word_ctrl.sv
// SRAM word controller: turns one 32-bit word request into two back-to-back
// 16-bit accesses on an external asynchronous SRAM (low half at the even
// half-word address, high half at the odd one), then spends one completion
// cycle with the SRAM idle before accepting the next request.
//
// All SRAM pins come straight from registers that are loaded from the
// *next* state, so the address, strobes and data drive are stable for the
// whole LO and HI cycles and never glitch.
module sram_word_ctrl #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  sram_word_ctrl_if.slave   bus,
  output logic [ADDR_W:0]   SRAM_A,
  inout  wire  [DATA_W/2-1:0] SRAM_D,
  output logic              SRAM_CE_n,
  output logic              SRAM_LB_n,
  output logic              SRAM_UB_n,
  output logic              SRAM_OE_n,
  output logic              SRAM_WE_n
);

  localparam int HW = DATA_W / 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // FSM and latched request
  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wd;
  logic              r_is_wr;

  // Read assembly
  logic [HW-1:0]     r_lo;
  logic [DATA_W-1:0] r_rd_data;

  // Registered SRAM pin drivers
  logic [ADDR_W:0]   r_sram_a;
  logic              r_ce_n;
  logic              r_lb_n;
  logic              r_ub_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_d_drv;
  logic [HW-1:0]     r_d_out;

  // Values feeding the pin registers: in IDLE the request has not been
  // latched yet, so the LO-cycle pins are taken directly from the bus.
  logic              w_req;
  logic [ADDR_W-1:0] w_nx_addr;
  logic [DATA_W-1:0] w_nx_wd;
  logic              w_nx_wr;

  assign w_req     = bus.we | bus.re;
  assign w_nx_addr = (r_state == IDLE) ? bus.addr : r_addr;
  assign w_nx_wd   = (r_state == IDLE) ? bus.wd   : r_wd;
  assign w_nx_wr   = (r_state == IDLE) ? bus.we   : r_is_wr;

  // Next-state logic: IDLE waits for a request, then LO -> HI -> DONE -> IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_state_next = LO;
      LO:      w_state_next = HI;
      HI:      w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register and request latch (write wins when we and re are both high)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wd    <= '0;
      r_is_wr <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_req) begin
        r_addr  <= bus.addr;
        r_wd    <= bus.wd;
        r_is_wr <= bus.we;
      end
    end
  end

  // Read data capture: low half at the end of LO, full word at the end of HI
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lo      <= '0;
      r_rd_data <= '0;
    end else begin
      if (r_state == LO && !r_is_wr) begin
        r_lo <= SRAM_D;
      end
      if (r_state == HI && !r_is_wr) begin
        r_rd_data <= {SRAM_D, r_lo};
      end
    end
  end

  // SRAM pin registers, loaded for the state being entered; the address is
  // a plain concatenation with the half-word select, so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sram_a <= '0;
      r_ce_n   <= 1'b1;
      r_lb_n   <= 1'b1;
      r_ub_n   <= 1'b1;
      r_oe_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_d_drv  <= 1'b0;
      r_d_out  <= '0;
    end else begin
      case (w_state_next)
        LO: begin
          r_sram_a <= {w_nx_addr, 1'b0};
          r_ce_n   <= 1'b0;
          r_lb_n   <= 1'b0;
          r_ub_n   <= 1'b0;
          r_oe_n   <= w_nx_wr;
          r_we_n   <= ~w_nx_wr;
          r_d_drv  <= w_nx_wr;
          r_d_out  <= w_nx_wd[HW-1:0];
        end
        HI: begin
          r_sram_a <= {w_nx_addr, 1'b1};
          r_ce_n   <= 1'b0;
          r_lb_n   <= 1'b0;
          r_ub_n   <= 1'b0;
          r_oe_n   <= w_nx_wr;
          r_we_n   <= ~w_nx_wr;
          r_d_drv  <= w_nx_wr;
          r_d_out  <= w_nx_wd[DATA_W-1:HW];
        end
        default: begin
          // Address is left where it was; only the strobes and the data
          // drive matter while the SRAM is deselected.
          r_ce_n  <= 1'b1;
          r_lb_n  <= 1'b1;
          r_ub_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_we_n  <= 1'b1;
          r_d_drv <= 1'b0;
        end
      endcase
    end
  end

  // Stall is combinational so the arbiter freezes in the same cycle a
  // request first appears; it drops in DONE so the requester can advance.
  assign bus.stall = ~reset & (((r_state == IDLE) & w_req) |
                               (r_state == LO) | (r_state == HI));
  assign bus.rd_data = r_rd_data;

  assign SRAM_A    = r_sram_a;
  assign SRAM_CE_n = r_ce_n;
  assign SRAM_LB_n = r_lb_n;
  assign SRAM_UB_n = r_ub_n;
  assign SRAM_OE_n = r_oe_n;
  assign SRAM_WE_n = r_we_n;
  assign SRAM_D    = r_d_drv ? r_d_out : {HW{1'bz}};

endmodule
